// File: rtl/sm_hex_scan_display_if.sv
// Bundle of the display driver's data/control inputs and the scanned display outputs.
// master = the side that supplies data (CPU top or bench); slave = the display driver.
interface sm_hex_scan_display_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              freeze;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_in;
  logic [6:0]        seg_out;
  logic              dp_out;
  logic [DIGITS-1:0] an_out;
  logic              frame;

  modport master (
    output data_in, load, freeze, blank_lz, dp_in,
    input  seg_out, dp_out, an_out, frame
  );

  modport slave (
    input  data_in, load, freeze, blank_lz, dp_in,
    output seg_out, dp_out, an_out, frame
  );
endinterface

// File: rtl/sm_hex_scan_display.sv
// Multiplexed N-digit hex display driver with a shadow register that only
// commits at frame boundaries, leading-zero blanking, freeze and decimal points.
module sm_hex_scan_display #(
  parameter int DIGITS      = 8,
  parameter int DATA_W      = 32,
  parameter int SCAN_DIV    = 16,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input logic                 clk,
  input logic                 rst,
  sm_hex_scan_display_if.slave bus
);

  localparam int   NW      = 4 * DIGITS;
  localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   DIV_W   = $clog2(SCAN_DIV);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [NW-1:0]     shadow;
  logic [NW-1:0]     disp;
  logic              pending;
  logic              frame_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  logic              div_wrap;
  logic              last_digit;
  logic              boundary;
  logic              load_ok;
  logic [3:0]        nib;
  logic              blank_cur;
  logic [6:0]        seg_act;
  logic              dp_act;
  logic [DIGITS-1:0] an_act;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    div_wrap   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    last_digit = (idx == IDX_W'(DIGITS - 1));
    boundary   = div_wrap && last_digit;
    load_ok    = bus.load && !bus.freeze;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= boundary;
      if (div_wrap) begin
        div_cnt <= '0;
        idx     <= last_digit ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // A load in the boundary cycle wins over the commit clearing pending,
  // so it is shown one frame later instead of being dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (boundary && pending && !bus.freeze) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
      if (load_ok) begin
        shadow  <= NW'(bus.data_in);
        pending <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more significant nibble are 0.
  always_comb begin
    nib       = disp[{idx, 2'b00} +: 4];
    blank_cur = bus.blank_lz && (idx != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx) && disp[4*k +: 4] != 4'h0) begin
        blank_cur = 1'b0;
      end
    end
    seg_act     = blank_cur ? 7'h00 : hex7(nib);
    dp_act      = bus.dp_in[idx] && !blank_cur;
    an_act      = '0;
    an_act[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= {DIGITS{AN_INV}};
      seg_q <= {7{SEG_INV}};
      dp_q  <= SEG_INV;
    end else begin
      an_q  <= an_act ^ {DIGITS{AN_INV}};
      seg_q <= seg_act ^ {7{SEG_INV}};
      dp_q  <= dp_act ^ SEG_INV;
    end
  end

  assign bus.an_out  = an_q;
  assign bus.seg_out = seg_q;
  assign bus.dp_out  = dp_q;
  assign bus.frame   = frame_q;

endmodule

// File: tb/tb_sm_hex_scan_display.sv
// Directed bench for sm_hex_scan_display: 8 digits, SCAN_DIV=4, active-low
// anodes and segments; expected patterns are hand-derived constants.
module tb_sm_hex_scan_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_count   = 0;
  int   miscompares = 0;

  logic [6:0] exp_seg [8];
  logic [7:0] exp_dp;

  sm_hex_scan_display_if #(.DIGITS(8), .DATA_W(32)) bus_if ();

  sm_hex_scan_display #(
    .DIGITS(8), .DATA_W(32), .SCAN_DIV(4), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    bus_if.data_in = value;
    bus_if.load    = 1'b1;
    step(1);
    bus_if.load    = 1'b0;
  endtask

  task automatic wait_frame;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      if (bus_if.frame === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  // Waits for a frame start, then samples every digit while it is lit.
  task automatic check_frame(input string name);
    logic [7:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      step(k == 0 ? 1 : 4);
      an_exp  = ~(8'h01 << k);
      seg_exp = ~exp_seg[k];
      dp_exp  = ~exp_dp[k];
      checkOutput($sformatf("%s_an%0d", name, k), 32'(bus_if.an_out), 32'(an_exp));
      checkOutput($sformatf("%s_seg%0d", name, k), 32'(bus_if.seg_out), 32'(seg_exp));
      checkOutput($sformatf("%s_dp%0d", name, k), 32'(bus_if.dp_out), 32'(dp_exp));
    end
  endtask

  initial begin
    logic [7:0] an_exp;
    bus_if.data_in  = '0;
    bus_if.load     = 1'b0;
    bus_if.freeze   = 1'b0;
    bus_if.blank_lz = 1'b0;
    bus_if.dp_in    = '0;

    $display("[TB] reset");
    rst = 1'b1;
    step(3);
    checkOutput("rst_an", 32'(bus_if.an_out), 32'hFF);
    checkOutput("rst_seg", 32'(bus_if.seg_out), 32'h7F);
    checkOutput("rst_dp", 32'(bus_if.dp_out), 32'h1);
    checkOutput("rst_frame", 32'(bus_if.frame), 32'h0);
    rst = 1'b0;
    step(1);
    checkOutput("first_an", 32'(bus_if.an_out), 32'hFE);
    checkOutput("first_seg", 32'(bus_if.seg_out), 32'h40);

    $display("[TB] scan walk and frame period");
    for (int c = 2; c <= 64; c++) begin
      step(1);
      an_exp = ~(8'h01 << (((c - 1) / 4) % 8));
      checkOutput($sformatf("scan_an_c%0d", c), 32'(bus_if.an_out), 32'(an_exp));
      checkOutput($sformatf("scan_frame_c%0d", c), 32'(bus_if.frame), (c % 32 == 0) ? 32'd1 : 32'd0);
    end

    $display("[TB] decode");
    applyStimulus(32'h89AB_CDEF);
    exp_seg = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
    exp_dp  = 8'h00;
    check_frame("dec");

    $display("[TB] blanking");
    bus_if.blank_lz = 1'b1;
    bus_if.dp_in    = 8'h06;
    applyStimulus(32'h0000_00A0);
    exp_seg = '{7'h3F, 7'h77, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_dp  = 8'h02;
    check_frame("blz1");
    bus_if.blank_lz = 1'b0;
    exp_seg = '{7'h3F, 7'h77, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    exp_dp  = 8'h06;
    check_frame("blz0");
    bus_if.dp_in = 8'h00;

    $display("[TB] tear-free");
    wait_frame();
    applyStimulus(32'h1);
    checkOutput("tear_d0_old", 32'(bus_if.seg_out), 32'h40);
    applyStimulus(32'h2);
    step(27);
    checkOutput("tear_d7_an", 32'(bus_if.an_out), 32'h7F);
    checkOutput("tear_d7_old", 32'(bus_if.seg_out), 32'h40);
    wait_frame();
    step(1);
    checkOutput("tear_d0_new", 32'(bus_if.seg_out), 32'h24);
    step(30);
    applyStimulus(32'h3);
    checkOutput("bnd_frame", 32'(bus_if.frame), 32'h1);
    step(1);
    checkOutput("bnd_d0_held", 32'(bus_if.seg_out), 32'h24);
    wait_frame();
    step(1);
    checkOutput("bnd_d0_new", 32'(bus_if.seg_out), 32'h30);

    $display("[TB] freeze");
    applyStimulus(32'h5);
    bus_if.freeze = 1'b1;
    applyStimulus(32'h6);
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      step(1);
      checkOutput($sformatf("frz_hold%0d", f), 32'(bus_if.seg_out), 32'h30);
    end
    bus_if.freeze = 1'b0;
    wait_frame();
    step(1);
    checkOutput("frz_release", 32'(bus_if.seg_out), 32'h12);

    $display("[TB] reset mid-frame");
    applyStimulus(32'h7);
    rst = 1'b1;
    step(1);
    checkOutput("mrst_an", 32'(bus_if.an_out), 32'hFF);
    checkOutput("mrst_seg", 32'(bus_if.seg_out), 32'h7F);
    checkOutput("mrst_frame", 32'(bus_if.frame), 32'h0);
    rst = 1'b0;
    step(1);
    checkOutput("mrst_an0", 32'(bus_if.an_out), 32'hFE);
    checkOutput("mrst_seg0", 32'(bus_if.seg_out), 32'h40);
    wait_frame();
    step(1);
    checkOutput("mrst_lost", 32'(bus_if.seg_out), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
